// File: rtl/dma_read_engine_pkg.sv
// rtl/dma_read_engine_pkg.sv - shared encodings and constants for the DMA read engine
//
// Purpose: TLP type codes, completion status codes, default tag base, the
// 4 KB request boundary and the engine state encoding.
package dma_read_engine_pkg;

  localparam logic [3:0] RQ_MEM_RD = 4'b0000;
  localparam logic [3:0] RQ_MEM_WR = 4'b0001;

  localparam logic [2:0] CPL_SC  = 3'b000;  // successful completion
  localparam logic [2:0] CPL_UR  = 3'b001;  // unsupported request
  localparam logic [2:0] CPL_CRS = 3'b010;  // config retry status
  localparam logic [2:0] CPL_CA  = 3'b100;  // completer abort

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'h80;

  localparam int BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } dma_state_e;

endpackage

// File: rtl/dma_tag_pool.sv
// rtl/dma_tag_pool.sv - outstanding read tag pool with per-tag local offset
//
// Purpose: tracks which tags are free, hands out the lowest free tag and keeps
// the next local DWord address for each outstanding tag.
// Ports:
//   alloc_en/alloc_offset   reserve alloc_tag and store its starting offset
//   any_free/alloc_tag      a tag is available / lowest free tag index
//   rel_en/rel_tag          return a tag to the pool
//   upd_en/upd_tag/upd_offset  overwrite the offset of an outstanding tag
//   rd_tag/rd_offset/rd_busy   lookup port (offset and outstanding flag)
//   all_free                no tag outstanding
module dma_tag_pool
  import dma_read_engine_pkg::*;
#(
  parameter int TAG_BITS = 3,
  parameter int OFF_W    = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_en,
  input  logic [OFF_W-1:0]    alloc_offset,
  output logic                any_free,
  output logic [TAG_BITS-1:0] alloc_tag,
  input  logic                rel_en,
  input  logic [TAG_BITS-1:0] rel_tag,
  input  logic                upd_en,
  input  logic [TAG_BITS-1:0] upd_tag,
  input  logic [OFF_W-1:0]    upd_offset,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic [OFF_W-1:0]    rd_offset,
  output logic                rd_busy,
  output logic                all_free
);

  localparam int NTAGS = 1 << TAG_BITS;

  logic [NTAGS-1:0] free_q;
  logic [OFF_W-1:0] off_q [NTAGS];

  // Scan from the top so the lowest free index is the one left standing.
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_tag = TAG_BITS'(i);
    end
  end

  assign any_free  = |free_q;
  assign all_free  = &free_q;
  assign rd_offset = off_q[rd_tag];
  assign rd_busy   = !free_q[rd_tag];

  // The free vector is registered, so a tag released this cycle only becomes
  // allocatable next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= '1;
      for (int i = 0; i < NTAGS; i++) off_q[i] <= '0;
    end else begin
      if (alloc_en) free_q[alloc_tag] <= 1'b0;
      if (rel_en)   free_q[rel_tag]   <= 1'b1;
      if (upd_en)   off_q[upd_tag]    <= upd_offset;
      if (alloc_en) off_q[alloc_tag]  <= alloc_offset;
    end
  end

endmodule

// File: rtl/dma_read_engine.sv
// rtl/dma_read_engine.sv - host-to-FPGA DMA read initiator (RQ requests, RC payload to local buffer)
//
// Purpose: splits a host buffer into memory read requests (max MAX_RD_DW
// DWords, never crossing 4 KB), tracks tags, and writes completion payload to
// a DWord-addressed local buffer.
// Ports:
//   start/host_addr/len_dw/local_base/requester_id  transfer programming
//   busy/done/error                                 transfer status
//   rq_*                                            request formatter interface
//   rc_*                                            completion parser interface
//   lb_wr_*                                         local buffer write port
module dma_read_engine
  import dma_read_engine_pkg::*;
#(
  parameter int         DATA_WIDTH = 256,
  parameter int         TAG_BITS   = 3,
  parameter logic [7:0] TAG_BASE   = TAG_BASE_DEFAULT,
  parameter int         MAX_RD_DW  = 32,
  parameter int         LEN_W      = 16,
  parameter int         LOCAL_AW   = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [63:0]             host_addr,
  input  logic [LEN_W-1:0]        len_dw,
  input  logic [LOCAL_AW-1:0]     local_base,
  input  logic [15:0]             requester_id,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    rq_ready,
  output logic                    rq_valid,
  output logic [3:0]              rq_type,
  output logic                    rq_sop,
  output logic                    rq_last,
  output logic [63:0]             rq_addr,
  output logic [10:0]             rq_dword_count,
  output logic [7:0]              rq_tag,
  output logic [15:0]             rq_requester_id,
  output logic [2:0]              rq_tc,
  input  logic                    rc_desc_valid,
  input  logic                    rc_data_valid,
  input  logic                    rc_data_sop,
  input  logic                    rc_data_eop,
  input  logic [7:0]              rc_tag,
  input  logic [2:0]              rc_status,
  input  logic [3:0]              rc_error_code,
  input  logic                    rc_request_completed,
  input  logic [DATA_WIDTH-1:0]   rc_payload,
  input  logic [DATA_WIDTH/32-1:0] rc_payload_keep,
  output logic                    lb_wr_en,
  output logic [LOCAL_AW-1:0]     lb_wr_addr,
  output logic [DATA_WIDTH-1:0]   lb_wr_data,
  output logic [DATA_WIDTH/32-1:0] lb_wr_keep
);

  localparam int NDW   = DATA_WIDTH / 32;
  localparam int NTAGS = 1 << TAG_BITS;
  localparam int CW    = LEN_W + 1;

  dma_state_e state_q, state_d;

  logic [63:0]         next_addr_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [LOCAL_AW-1:0] next_off_q;
  logic                error_q;
  logic [15:0]         rid_q;
  logic                rq_valid_q;
  logic [63:0]         rq_addr_q;
  logic [10:0]         rq_cnt_q;
  logic [7:0]          rq_tag_q;

  logic [TAG_BITS-1:0] lat_idx_q;
  logic                drop_q;
  logic                free_lat_q;

  logic                any_free, all_free, rd_busy;
  logic [TAG_BITS-1:0] alloc_tag, cur_idx;
  logic [LOCAL_AW-1:0] rd_offset, pop;

  // ---------------- request chunking ----------------
  logic [CW-1:0] room, chunk;
  logic          load;

  always_comb begin
    room  = CW'(BOUNDARY_4K / 4) - CW'(next_addr_q[11:2]);
    chunk = CW'(MAX_RD_DW);
    if ({1'b0, remaining_q} < chunk) chunk = {1'b0, remaining_q};
    if (room < chunk) chunk = room;
  end

  // ---------------- completion decode ----------------
  logic       desc, in_pool, desc_known, bad_status;
  logic       desc_drop, desc_free, set_err;
  logic       cur_drop, cur_free, wr_beat, rel_en;
  logic [7:0] tag_rel;

  assign desc       = rc_desc_valid && rc_data_valid && rc_data_sop;
  assign tag_rel    = rc_tag - TAG_BASE;
  assign in_pool    = tag_rel < 8'(NTAGS);
  assign cur_idx    = desc ? tag_rel[TAG_BITS-1:0] : lat_idx_q;
  assign desc_known = in_pool && rd_busy;
  assign bad_status = (rc_status != CPL_SC) || (rc_error_code != 4'd0);
  assign desc_drop  = !busy || !desc_known || bad_status;
  // A failed completion still retires its tag so the engine can drain.
  assign desc_free  = desc_known && (bad_status || rc_request_completed);
  assign set_err    = desc && busy && (!desc_known || bad_status);
  assign cur_drop   = desc ? desc_drop : drop_q;
  assign cur_free   = desc ? desc_free : free_lat_q;
  assign wr_beat    = rc_data_valid && !cur_drop;
  assign rel_en     = rc_data_valid && rc_data_eop && cur_free;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NDW; i++) pop = pop + LOCAL_AW'(rc_payload_keep[i]);
  end

  // A request is built into the output register whenever the slot is empty or
  // is being accepted this cycle; the tag is reserved at that point so the
  // presented fields never change while rq_valid waits for rq_ready.
  assign load = (state_q == ST_ISSUE) && !error_q && !set_err &&
                (remaining_q != '0) && any_free && (!rq_valid_q || rq_ready);

  dma_tag_pool #(
    .TAG_BITS (TAG_BITS),
    .OFF_W    (LOCAL_AW)
  ) u_tag_pool (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_en     (load),
    .alloc_offset (next_off_q),
    .any_free     (any_free),
    .alloc_tag    (alloc_tag),
    .rel_en       (rel_en),
    .rel_tag      (cur_idx),
    .upd_en       (wr_beat),
    .upd_tag      (cur_idx),
    .upd_offset   (rd_offset + pop),
    .rd_tag       (cur_idx),
    .rd_offset    (rd_offset),
    .rd_busy      (rd_busy),
    .all_free     (all_free)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (len_dw == '0) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy = 1'b1;
        if (error_q || remaining_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (all_free && !rq_valid_q) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q <= '0;
      remaining_q <= '0;
      next_off_q  <= '0;
      error_q     <= 1'b0;
      rid_q       <= '0;
      rq_valid_q  <= 1'b0;
      rq_addr_q   <= '0;
      rq_cnt_q    <= '0;
      rq_tag_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        next_addr_q <= host_addr & ~64'h3;
        remaining_q <= len_dw;
        next_off_q  <= local_base;
        error_q     <= 1'b0;
        rid_q       <= requester_id;
      end
      if (set_err) error_q <= 1'b1;
      if (load) begin
        rq_valid_q  <= 1'b1;
        rq_addr_q   <= next_addr_q;
        rq_cnt_q    <= 11'(chunk);
        rq_tag_q    <= TAG_BASE + 8'(alloc_tag);
        next_addr_q <= next_addr_q + (64'(chunk) << 2);
        remaining_q <= remaining_q - LEN_W'(chunk);
        next_off_q  <= next_off_q + LOCAL_AW'(chunk);
      end else if (rq_valid_q && rq_ready) begin
        rq_valid_q <= 1'b0;
      end
    end
  end

  // Per-completion context held from the descriptor beat to eop; between
  // completions stray beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx_q  <= '0;
      drop_q     <= 1'b1;
      free_lat_q <= 1'b0;
    end else if (rc_data_valid && rc_data_eop) begin
      drop_q     <= 1'b1;
      free_lat_q <= 1'b0;
    end else if (desc) begin
      lat_idx_q  <= tag_rel[TAG_BITS-1:0];
      drop_q     <= desc_drop;
      free_lat_q <= desc_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_wr_en   <= 1'b0;
      lb_wr_addr <= '0;
      lb_wr_data <= '0;
      lb_wr_keep <= '0;
    end else begin
      lb_wr_en <= wr_beat;
      if (wr_beat) begin
        lb_wr_addr <= rd_offset;
        lb_wr_data <= rc_payload;
        lb_wr_keep <= rc_payload_keep;
      end
    end
  end

  assign error           = error_q;
  assign rq_valid        = rq_valid_q;
  assign rq_type         = RQ_MEM_RD;
  assign rq_sop          = rq_valid_q;
  assign rq_last         = rq_valid_q;
  assign rq_addr         = rq_addr_q;
  assign rq_dword_count  = rq_cnt_q;
  assign rq_tag          = rq_tag_q;
  assign rq_requester_id = rid_q;
  assign rq_tc           = 3'b000;

endmodule

// File: doc/dma_read_engine.md
Name: dma_read_engine

Overview:
Host-to-FPGA DMA read initiator. It is the read-side counterpart of the existing BAR0 DMA-write path. On a start pulse it splits a host buffer into PCIe Memory Read requests on the RQ formatter interface. It tracks outstanding tags, consumes completions from the RC parser, and writes returned payload into a local DWord-addressed buffer. It sits beside the register/control logic, which programs it through its start/status ports.

Parameters:
DATA_WIDTH, 256, RQ/RC datapath width in bits (DATA_WIDTH/32 DWords per beat)
TAG_BITS, 3, log2 of outstanding-request tag pool (8 tags)
TAG_BASE, 8'h80, first PCIe tag used; tags are TAG_BASE..TAG_BASE+2^TAG_BITS-1
MAX_RD_DW, 32, maximum DWords per read request (128 B)
LEN_W, 16, width of transfer length in DWords
LOCAL_AW, 14, local buffer DWord address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; launches a transfer when idle
host_addr  in  64  host IOVA; bits [1:0] ignored (treated as 0)
len_dw  in  LEN_W  transfer length in DWords
local_base  in  LOCAL_AW  first local DWord address
requester_id  in  16  own BDF, copied to rq_requester_id
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
error  out  1  sticky error of the last transfer; cleared on accepted start
rq_ready  in  1  RQ formatter ready
rq_valid  out  1  request valid; held until rq_valid&&rq_ready
rq_type  out  4  always 4'b0000 (memory read)
rq_sop, rq_last  out  1 each  both 1 on every request
rq_addr  out  64  request host address
rq_dword_count  out  11  request length in DWords
rq_tag  out  8  request tag
rq_requester_id  out  16  = requester_id
rq_tc  out  3  always 0
rc_desc_valid, rc_data_valid, rc_data_sop, rc_data_eop  in  1 each  RC parser strobes
rc_tag  in  8; rc_status  in  3; rc_error_code  in  4; rc_request_completed  in  1
rc_payload  in  DATA_WIDTH; rc_payload_keep  in  DATA_WIDTH/32
lb_wr_en  out  1  local buffer write strobe
lb_wr_addr  out  LOCAL_AW  DWord address of payload DW0
lb_wr_data  out  DATA_WIDTH  = rc_payload, registered
lb_wr_keep  out  DATA_WIDTH/32  = rc_payload_keep, registered

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, state IDLE, tag pool all free. A reset mid-transfer abandons the transfer with no done pulse.
- States:
  - IDLE: on start, latch addr/len/local_base, clear error, busy=1. len_dw=0 goes straight to FINISH.
  - ISSUE: issue requests while remaining>0 and a tag is free.
  - DRAIN: remaining=0 or error set; wait until all tags are free.
  - FINISH: done=1 for one cycle, busy=0, back to IDLE.
- start while busy: ignored.
- Chunk size = min(MAX_RD_DW, remaining, (4096-addr[11:0])>>2). No request crosses a 4 KB boundary.
- Allocate the lowest free tag. Record per tag: local DWord offset = local_base + DWords already requested.
- On rq_valid&&rq_ready: addr += 4*chunk, remaining -= chunk, tag marked busy. The next request may present the following cycle.
- Tag pool full: rq_valid stays 0. If a tag frees in cycle N, allocation of it occurs no earlier than N+1.
- Completions:
  - rc_desc_valid coincides with the sop beat and carries rc_tag. Data beats of that completion use the latched tag until eop.
  - Payload is DWord-aligned at bit 0.
  - Each beat writes lb_wr_* one cycle after the beat (latency 1). The tag's offset then advances by popcount(rc_payload_keep).
  - Completions split at RCB advance the same tag's offset. The tag is freed at eop of a completion whose descriptor had rc_request_completed=1.
- Errors (set sticky error, stop issuing, go to DRAIN):
  - rc_status≠0 or rc_error_code≠0: data dropped; the tag is freed at that eop.
  - rc_tag outside the pool or not outstanding while busy: data dropped. Such completions while idle are silently dropped.
- Simultaneous free and allocate on different tags in one cycle is legal.

Decomposition:
- Shared package: RQ/RC type encodings (RQ_MEM_RD=4'b0000, RQ_MEM_WR=4'b0001), CPL status codes, TAG_BASE, 4 KB boundary constant.
- One sub-module, dma_tag_pool: free-bit vector, lowest-free priority encoder, per-tag offset RAM, alloc/free ports.

Test Plan:
- host_addr=0x1000, len_dw=64, rq_ready=1, single completions per tag → two requests (32 DW each, tags 0x80,0x81); 8 writes at local_base..+63; done after the last eop; error=0.
- host_addr=0x1FF0, len_dw=16 → requests of 4 DW @0x1FF0 then 12 DW @0x2000; no 4 KB crossing.
- len_dw=512, completions withheld → exactly 8 requests, then rq_valid=0. Release tag 0x83 → the next request uses tag 0x83 one cycle later.
- Completions returned out of order (tag 0x81 before 0x80), each split in two 64 B completions → every DW lands at its correct local address.
- Completion with rc_status=3'b001 on tag 0x80 → no lb_wr_en for it; no further requests; done after outstanding tags drain; error=1.
- rst_n low mid-transfer, then a start with len_dw=0 → busy=0 after reset, then a done pulse with no RQ traffic.
